// File: rtl/wb_regfile.sv
// Writeback stage: result select, 32-entry register file commit, two decode read ports, write counter.
// Optional macro WB_BYPASS_EN: read ports return the same-cycle writeback value on an index match.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWriteW,
    input  logic              MemtoRegW,
    input  logic [DATA_W-1:0] ReadDataW,
    input  logic [DATA_W-1:0] AluOutW,
    input  logic [ADDR_W-1:0] WriteRegW,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] ResultW,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [CNT_W-1:0]  wrCount;
    logic              commit;
    logic [DATA_W-1:0] arrRd1;
    logic [DATA_W-1:0] arrRd2;

    assign ResultW = MemtoRegW ? ReadDataW : AluOutW;

    // Writes aimed at $zero are dropped here so they neither land nor count.
    assign commit = RegWriteW && (WriteRegW != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wrCount <= '0;
        end else if (commit) begin
            regs[WriteRegW] <= ResultW;
            wrCount         <= wrCount + CNT_W'(1);
        end
    end

    assign wr_count = wrCount;

    // Entry 0 is gated at the read side, so its storage content never matters.
    always_comb begin
        arrRd1 = '0;
        arrRd2 = '0;
        if (A1 != '0) arrRd1 = regs[A1];
        if (A2 != '0) arrRd2 = regs[A2];
    end

`ifdef WB_BYPASS_EN
    logic bypass1;
    logic bypass2;

    // No bypass under reset: the array is being cleared and the write is discarded.
    assign bypass1 = rst_n && commit && (WriteRegW == A1);
    assign bypass2 = rst_n && commit && (WriteRegW == A2);

    assign RD1 = bypass1 ? ResultW : arrRd1;
    assign RD2 = bypass2 ? ResultW : arrRd2;
`else
    assign RD1 = arrRd1;
    assign RD2 = arrRd2;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: array/counter model plus directed vectors.
// A second instance with a 4-bit counter exercises counter wrap.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic [31:0] ReadDataW;
    logic [31:0] AluOutW;
    logic [4:0]  WriteRegW;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1, RD2, ResultW, wrCount;
    logic [31:0] RD1s, RD2s, ResultWs;
    logic [3:0]  wrCountS;

    int nCompared   = 0;
    int nMismatched = 0;
    logic chkEn = 1'b0;

    logic [31:0] model [32];
    logic [31:0] modelCnt;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ReadDataW(ReadDataW), .AluOutW(AluOutW), .WriteRegW(WriteRegW),
        .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .ResultW(ResultW), .wr_count(wrCount)
    );

    wb_regfile #(.CNT_W(4)) dutSmall (
        .clk(clk), .rst_n(rst_n), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ReadDataW(ReadDataW), .AluOutW(AluOutW), .WriteRegW(WriteRegW),
        .A1(A1), .A2(A2), .RD1(RD1s), .RD2(RD2s), .ResultW(ResultWs), .wr_count(wrCountS)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] expResult();
        return MemtoRegW ? ReadDataW : AluOutW;
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (rst_n && RegWriteW && WriteRegW != 5'd0 && WriteRegW == a) return expResult();
`endif
        return model[a];
    endfunction

    // Model: architectural register file and write count as the writeback rules define them.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] <= 32'd0;
            modelCnt <= 32'd0;
        end else if (RegWriteW && WriteRegW != 5'd0) begin
            model[WriteRegW] <= expResult();
            modelCnt <= modelCnt + 32'd1;
        end
    end

    always @(negedge clk) begin
        check("ResultW", ResultW, expResult());
        check("ResultW_small", ResultWs, expResult());
        if (chkEn) begin
            check("RD1", RD1, expRead(A1));
            check("RD2", RD2, expRead(A2));
            check("wr_count", wrCount, modelCnt);
            check("RD1_small", RD1s, expRead(A1));
            check("RD2_small", RD2s, expRead(A2));
            check("wr_count_small", {28'd0, wrCountS}, modelCnt & 32'hF);
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; RegWriteW = 1'b0; MemtoRegW = 1'b0;
        ReadDataW = 32'd0; AluOutW = 32'd0; WriteRegW = 5'd0; A1 = 5'd0; A2 = 5'd0;

        nextCycle();
        chkEn = 1'b1;
        nextCycle();
        rst_n = 1'b1;

        // Reset state: every entry reads zero, ResultW follows inputs.
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(31 - i);
            AluOutW = 32'(i * 3); ReadDataW = 32'h8000_0000 | 32'(i);
            MemtoRegW = (i % 2) == 1;
            @(negedge clk);
            check("reset_RD1", RD1, 32'd0);
            check("reset_RD2", RD2, 32'd0);
            check("reset_cnt", wrCount, 32'd0);
            if (i == 7) check("reset_ResultW", ResultW, 32'h8000_0007);
            nextCycle();
        end

        // ALU commit to r8.
        RegWriteW = 1'b1; MemtoRegW = 1'b0; AluOutW = 32'h0000_1234; WriteRegW = 5'd8;
        nextCycle();
        RegWriteW = 1'b0; A1 = 5'd8;
        @(negedge clk);
        check("alu_RD1", RD1, 32'h0000_1234);
        check("alu_cnt", wrCount, 32'd1);
        nextCycle();

        // Load commit to r31.
        RegWriteW = 1'b1; MemtoRegW = 1'b1; ReadDataW = 32'hDEAD_BEEF; AluOutW = 32'h5; WriteRegW = 5'd31;
        @(negedge clk);
        check("load_ResultW", ResultW, 32'hDEAD_BEEF);
        nextCycle();
        RegWriteW = 1'b0; A2 = 5'd31;
        @(negedge clk);
        check("load_RD2", RD2, 32'hDEAD_BEEF);
        check("load_cnt", wrCount, 32'd2);
        nextCycle();

        // Write to $zero is dropped and not counted.
        RegWriteW = 1'b1; MemtoRegW = 1'b0; AluOutW = 32'hFFFF_FFFF; WriteRegW = 5'd0; A1 = 5'd0;
        nextCycle();
        RegWriteW = 1'b0;
        @(negedge clk);
        check("zero_RD1", RD1, 32'd0);
        check("zero_cnt", wrCount, 32'd2);
        nextCycle();

        // Same-cycle read of a register being written.
        RegWriteW = 1'b1; AluOutW = 32'h0000_1111; WriteRegW = 5'd3;
        nextCycle();
        AluOutW = 32'h0000_A5A5; A1 = 5'd3; A2 = 5'd3;
        @(negedge clk);
`ifdef WB_BYPASS_EN
        check("same_RD1", RD1, 32'h0000_A5A5);
        check("same_RD2", RD2, 32'h0000_A5A5);
`else
        check("same_RD1", RD1, 32'h0000_1111);
        check("same_RD2", RD2, 32'h0000_1111);
`endif
        nextCycle();
        RegWriteW = 1'b0;
        @(negedge clk);
        check("after_RD1", RD1, 32'h0000_A5A5);
        check("after_RD2", RD2, 32'h0000_A5A5);
        check("after_cnt", wrCount, 32'd4);
        nextCycle();

        // Reset wins over a same-cycle commit.
        RegWriteW = 1'b1; AluOutW = 32'h77; WriteRegW = 5'd4;
        nextCycle();
        rst_n = 1'b0; AluOutW = 32'h99; A1 = 5'd4;
        @(negedge clk);
        check("rst_bypass_off", RD1, 32'h77);
        nextCycle();
        rst_n = 1'b1; RegWriteW = 1'b0;
        @(negedge clk);
        check("rst_RD1", RD1, 32'd0);
        check("rst_RD2", RD2, 32'd0);
        check("rst_cnt", wrCount, 32'd0);
        nextCycle();

        // Sixteen commits: the 4-bit counter reaches 15 then wraps to 0.
        for (int k = 0; k < 16; k++) begin
            RegWriteW = 1'b1; MemtoRegW = (k % 3) == 0;
            WriteRegW = 5'((k * 7) % 31 + 1);
            AluOutW = 32'h100 + 32'(k); ReadDataW = 32'hC000_0000 + 32'(k);
            A1 = WriteRegW; A2 = 5'((k * 5) % 32);
            nextCycle();
            @(negedge clk);
            if (k == 14) check("wrap_15", {28'd0, wrCountS}, 32'd15);
            if (k == 15) begin
                check("wrap_0", {28'd0, wrCountS}, 32'd0);
                check("wide_16", wrCount, 32'd16);
            end
        end
        nextCycle();
        RegWriteW = 1'b0;
        repeat (3) nextCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
